// File: rtl/seq_level_step_if.sv
// Handshake bundle between the level sequencer and whatever drives it:
// counter value/enable and control inputs, plus the level/code/status outputs.
interface seq_level_step_if;
  logic [3:0] q;
  logic       en;
  logic       start;
  logic       abort;
  logic       loop;
  logic [2:0] level;
  logic [1:0] code;
  logic       wrap;
  logic       busy;
  logic       done;

  modport master (
    output q, en, start, abort, loop,
    input  level, code, wrap, busy, done
  );

  modport slave (
    input  q, en, start, abort, loop,
    output level, code, wrap, busy, done
  );
endinterface

// File: rtl/seq_level_step.sv
// Level sequencer: counts counter wraps and walks 8 levels, emitting a 2-bit
// code per level, with single-shot/loop modes and start/abort control.
module seq_level_step #(
  parameter logic [15:0] CODE_MAP = 16'hB4B4,
  parameter logic [3:0]  TERMINAL = 4'hF
) (
  input  logic              clk,
  input  logic              reset,
  seq_level_step_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_r, state_n;
  logic [2:0] level_r, level_n;
  logic [1:0] code_r;
  logic       wrap_r, wrap_n;
  logic       busy_r, done_r;
  logic       wev;

  function automatic logic [1:0] code_of(input logic [2:0] lv);
    return CODE_MAP[{lv, 1'b0} +: 2];
  endfunction

  // The counter rolls over on the same edge that consumes this event.
  assign wev = bus.en && (bus.q == TERMINAL);

  always_comb begin
    state_n = state_r;
    level_n = level_r;
    wrap_n  = 1'b0;
    if (bus.abort) begin
      state_n = IDLE;
      level_n = 3'd0;
    end else begin
      unique case (state_r)
        IDLE, DONE: begin
          // start beats a coincident wev here; the wev is simply dropped
          if (bus.start) begin
            state_n = RUN;
            level_n = 3'd0;
          end
        end
        RUN: begin
          if (wev) begin
            wrap_n = 1'b1;
            if (level_r != 3'd7) begin
              level_n = level_r + 3'd1;
            end else if (bus.loop) begin
              level_n = 3'd0;
            end else begin
              state_n = DONE;
            end
          end
        end
        default: begin
          state_n = IDLE;
          level_n = 3'd0;
        end
      endcase
    end
  end

  // Outputs are registered from next-state values so they move with level.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
      level_r <= 3'd0;
      code_r  <= code_of(3'd0);
      wrap_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      level_r <= level_n;
      code_r  <= code_of(level_n);
      wrap_r  <= wrap_n;
      busy_r  <= (state_n == RUN);
      done_r  <= (state_n == DONE);
    end
  end

  assign bus.level = level_r;
  assign bus.code  = code_r;
  assign bus.wrap  = wrap_r;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;

endmodule
